// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: VGA reads (deduplicated by a one-entry address tag) take priority,
// and queued pixel writes drain into repeat and blanking cycles.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [FIFO_AW:0]  fifo_level,
    output logic [15:0]       stall_cnt
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic [ADDR_W-1:0]  fifo_addr [DEPTH];
    logic [DATA_W-1:0]  fifo_data [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               last_valid;
    logic [ADDR_W-1:0]  last_addr;
    logic [1:0]         inflight;
    logic               full;
    logic               push;
    logic               do_read;
    logic               do_write;

    assign full       = (count == CNT_W'(DEPTH));
    assign wr_ready   = !full && !reset;
    assign push       = wr_valid && wr_ready;
    assign do_read    = rd_req && (!last_valid || (rd_addr != last_addr));
    assign do_write   = !do_read && (count != '0);
    assign fifo_level = count;

    // Entry storage needs no reset: occupancy lives entirely in count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            last_valid    <= 1'b0;
            last_addr     <= '0;
            inflight      <= '0;
            stall_cnt     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (do_read) begin
                mem_addr   <= rd_addr;
                last_addr  <= rd_addr;
                last_valid <= 1'b1;
            end else if (do_write) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
                mem_we    <= 1'b1;
                rd_ptr    <= rd_ptr + FIFO_AW'(1);
                // A write to the cached address makes the tag stale.
                if (fifo_addr[rd_ptr] == last_addr) begin
                    last_valid <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            case ({push, do_write})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Two-stage tracker: address out, RAM samples, data captured.
            inflight      <= {inflight[0], do_read};
            rd_data_valid <= inflight[1];
            if (inflight[1]) begin
                rd_data <= mem_rdata;
            end

            if (wr_valid && full && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [23:0] rd_data;
    logic        rd_data_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_we;
    logic [23:0] mem_rdata = '0;
    logic [2:0]  fifo_level;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    bit run_chk = 1'b0;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read-before-write, data one cycle after sampling.
    logic [23:0] ram [65536];
    logic [23:0] ram_rv;
    always @(posedge clk) begin
        ram_rv = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        mem_rdata <= ram_rv;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [23:0] init_word(input int i);
        return 24'(i * 40503) ^ 24'h5A5A5A;
    endfunction

    // Reference model: write queue, one-entry tag, memory image, reads due two edges later.
    typedef struct { logic [15:0] addr; logic [23:0] data; } wr_t;
    typedef struct { int due; logic [23:0] data; } rd_t;
    wr_t         mq[$];
    rd_t         pend[$];
    logic [23:0] ref_mem [65536];
    logic [15:0] m_addr = '0;
    logic [23:0] m_wdata = '0;
    logic        m_we = 1'b0;
    logic [23:0] m_rd_data = '0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_stall = '0;
    logic [15:0] m_tag = '0;
    logic        m_tag_v = 1'b0;
    int          cyc = 0;
    int          sz;
    bit          acc;
    wr_t         w;
    rd_t         r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            pend.delete();
            m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_rd_data = '0; m_rd_valid = 1'b0; m_stall = '0;
            m_tag = '0; m_tag_v = 1'b0;
        end else begin
            sz  = mq.size();
            acc = wr_valid && (sz < 4);
            if (wr_valid && sz == 4 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_rd_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_rd_data  = pend[0].data;
                m_rd_valid = 1'b1;
                void'(pend.pop_front());
            end
            m_we = 1'b0;
            if (rd_req && (!m_tag_v || rd_addr != m_tag)) begin
                m_addr  = rd_addr;
                m_tag   = rd_addr;
                m_tag_v = 1'b1;
                r.due   = cyc + 2;
                r.data  = ref_mem[rd_addr];
                pend.push_back(r);
            end else if (sz > 0) begin
                w = mq.pop_front();
                m_addr  = w.addr;
                m_wdata = w.data;
                m_we    = 1'b1;
                ref_mem[w.addr] = w.data;
                if (w.addr == m_tag) m_tag_v = 1'b0;
            end
            if (acc) begin
                w.addr = wr_addr;
                w.data = wr_data;
                mq.push_back(w);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("rd_data_valid", 32'(rd_data_valid), 32'(m_rd_valid));
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("wr_ready", 32'(wr_ready), 32'(mq.size() < 4));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end
    end

    int          k;
    int          pulses;
    int          we_seen;
    bit          acc_d;
    logic [15:0] seen[$];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = init_word(i);
            ref_mem[i] = ram[i];
        end
        ram[16'h0010] = 24'hAABBCC; ref_mem[16'h0010] = 24'hAABBCC;
        ram[16'h0011] = 24'h112233; ref_mem[16'h0011] = 24'h112233;

        // Reset state, including wr_ready held low while reset is asserted
        #2;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        tick(); tick();
        reset = 1'b0;
        run_chk = 1'b1;
        tick();
        chk("rel_mem_addr", 32'(mem_addr), 32'd0);
        chk("rel_rd_data", 32'(rd_data), 32'd0);
        chk("rel_fifo_level", 32'(fifo_level), 32'd0);
        chk("rel_stall", 32'(stall_cnt), 32'd0);
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);

        // Repeated VGA addresses fetch once each
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            rd_req  = (i < 8);
            rd_addr = (i < 4) ? 16'h0010 : 16'h0011;
            tick();
            if (rd_data_valid) pulses++;
            if (i == 0) chk("t2_addr0", 32'(mem_addr), 32'h0010);
            if (i == 2) begin
                chk("t2_data0", 32'(rd_data), 32'hAABBCC);
                chk("t2_valid0", 32'(rd_data_valid), 32'd1);
                chk("t2_model0", 32'(m_rd_data), 32'hAABBCC);
            end
            if (i == 4) chk("t2_addr1", 32'(mem_addr), 32'h0011);
            if (i == 6) chk("t2_data1", 32'(rd_data), 32'h112233);
        end
        chk("t2_pulses", 32'(pulses), 32'd2);

        // Single write during blanking
        wr_valid = 1'b1; wr_addr = 16'h0005; wr_data = 24'h123456;
        tick();
        wr_valid = 1'b0;
        chk("t3_level1", 32'(fifo_level), 32'd1);
        chk("t3_we_pre", 32'(mem_we), 32'd0);
        tick();
        chk("t3_we", 32'(mem_we), 32'd1);
        chk("t3_addr", 32'(mem_addr), 32'h0005);
        chk("t3_wdata", 32'(mem_wdata), 32'h123456);
        chk("t3_level0", 32'(fifo_level), 32'd0);
        tick();
        chk("t3_we_end", 32'(mem_we), 32'd0);

        // Fill the FIFO behind back-to-back reads, then drain in blanking
        k = 0;
        for (int c = 0; c < 8; c++) begin
            rd_req = 1'b1; rd_addr = 16'(16'h0100 + c);
            wr_valid = 1'b1; wr_addr = 16'(16'h0200 + k); wr_data = 24'(24'h300000 + k);
            acc_d = wr_ready;
            tick();
            if (acc_d) k++;
        end
        chk("t4_level", 32'(fifo_level), 32'd4);
        chk("t4_ready", 32'(wr_ready), 32'd0);
        chk("t4_stall", 32'(stall_cnt), 32'd4);
        seen.delete();
        for (int d = 0; d < 8; d++) begin
            rd_req = 1'b0;
            wr_valid = (k < 5); wr_addr = 16'(16'h0200 + k); wr_data = 24'(24'h300000 + k);
            acc_d = wr_ready && wr_valid;
            tick();
            if (mem_we) seen.push_back(mem_addr);
            if (acc_d) k++;
        end
        wr_valid = 1'b0;
        chk("t4_stall_end", 32'(stall_cnt), 32'd5);
        chk("t4_nwrites", 32'(seen.size()), 32'd5);
        for (int j = 0; j < 5 && j < seen.size(); j++)
            chk("t4_order", 32'(seen[j]), 32'(16'h0200 + j));

        // Write to the cached address forces a fresh fetch
        rd_req = 1'b1; rd_addr = 16'h0020;
        wr_valid = 1'b1; wr_addr = 16'h0020; wr_data = 24'hDEAD01;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("t5_we", 32'(mem_we), 32'd1);
        tick();
        chk("t5_reread_we", 32'(mem_we), 32'd0);
        chk("t5_reread_addr", 32'(mem_addr), 32'h0020);
        tick(); tick();
        chk("t5_data", 32'(rd_data), 32'hDEAD01);
        chk("t5_valid", 32'(rd_data_valid), 32'd1);

        // Reset mid-drain
        for (int c = 0; c < 4; c++) begin
            rd_req = 1'b1; rd_addr = 16'(16'h0400 + c);
            wr_valid = 1'b1; wr_addr = 16'(16'h0500 + c); wr_data = 24'(24'h0A0000 + c);
            tick();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        tick();
        chk("t6_we_pre", 32'(mem_we), 32'd1);
        chk("t6_level_pre", 32'(fifo_level), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("t6_we_async", 32'(mem_we), 32'd0);
        chk("t6_level_async", 32'(fifo_level), 32'd0);
        chk("t6_ready_async", 32'(wr_ready), 32'd0);
        tick(); tick();
        reset = 1'b0;
        we_seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_we) we_seen++;
        end
        chk("t6_no_writes", 32'(we_seen), 32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);

        // Randomized traffic with small address range to exercise hits and coherency
        for (int c = 0; c < 3000; c++) begin
            rd_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) rd_addr = 16'($urandom_range(0, 15));
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = 16'($urandom_range(0, 15));
            wr_data  = 24'($urandom);
            if (c == 1500) begin
                #1 reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        run_chk = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
